// File: rtl/pcie_wr_commit_tracker.sv
// pcie_wr_commit_tracker
// Counts posted writes issued on TX A until their commit completions return on
// RX B, runs a fence handshake that drains all outstanding writes, and flags
// protocol errors in a sticky error register.
// Optional build macro PCIE_WR_COMMIT_TRACKER_TAG_CHECK_EN adds a per-tag
// pending bitmap that catches duplicate issues and spurious commits by tag.
module pcie_wr_commit_tracker #(
  parameter int TAG_W = 10,
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_issue,
  input  logic [TAG_W-1:0] wr_issue_tag,
  input  logic             rx_b_tvalid,
  output logic             rx_b_tready,
  input  logic [TAG_W-1:0] rx_b_tag,
  input  logic             fence_req,
  output logic             fence_ack,
  output logic             wr_block,
  output logic [CNT_W-1:0] outstanding,
  output logic [2:0]       err,
  input  logic             err_clr
);

  typedef enum logic [1:0] {IDLE, DRAIN, ACK} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       err_q;
  logic             commit;
  logic             cnt_dec;
  logic             spur_err;
  logic             dup_err;
  logic             blocked;
  logic [CNT_W+1:0] cnt_res;
  logic [2:0]       new_err;

  // Saturating up/down count: result is {overflow, underflow, count}.
  function automatic logic [CNT_W+1:0] sat_count(input logic [CNT_W-1:0] c,
                                                 input logic inc,
                                                 input logic dec);
    logic [CNT_W+1:0] r;
    r = {2'b00, c};
    if (inc && !dec) begin
      if (c == {CNT_W{1'b1}}) r = {2'b10, c};
      else                    r = {2'b00, c + 1'b1};
    end else if (dec && !inc) begin
      if (c == '0) r = {2'b01, c};
      else         r = {2'b00, c - 1'b1};
    end
    return r;
  endfunction

  assign rx_b_tready = !rst;
  assign commit      = rx_b_tvalid && rx_b_tready;
  assign blocked     = (state != IDLE);

`ifdef PCIE_WR_COMMIT_TRACKER_TAG_CHECK_EN
  logic [2**TAG_W-1:0] pending;
  logic                cmt_hit;

  assign cmt_hit  = pending[rx_b_tag];
  assign cnt_dec  = commit && cmt_hit;
  assign spur_err = commit && !cmt_hit;
  // A same-tag commit in this cycle frees the bit before the issue re-sets it.
  assign dup_err  = wr_issue && pending[wr_issue_tag] &&
                    !(commit && (rx_b_tag == wr_issue_tag));

  // Pending bitmap: clear on commit, then set on issue (set wins on same tag).
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (commit)   pending[rx_b_tag]     <= 1'b0;
      if (wr_issue) pending[wr_issue_tag] <= 1'b1;
    end
  end
`else
  logic unused_tags;

  assign unused_tags = ^{wr_issue_tag, rx_b_tag};
  assign cnt_dec     = commit;
  assign spur_err    = 1'b0;
  assign dup_err     = 1'b0;
`endif

  assign cnt_res = sat_count(cnt_q, wr_issue, cnt_dec);
  assign new_err = {wr_issue && blocked,
                    dup_err  || cnt_res[CNT_W+1],
                    spur_err || cnt_res[CNT_W]};

  // Outstanding counter and sticky errors; a new error beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_res[CNT_W-1:0];
      err_q <= (err_clr ? 3'b000 : err_q) | new_err;
    end
  end

  // Fence state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Fence next state: drain completes once the count is zero with no issue.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (fence_req) state_nxt = DRAIN;
      DRAIN:   if ((cnt_q == '0) && !wr_issue) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign fence_ack   = !rst && (state == ACK);
  assign wr_block    = !rst && blocked;
  assign outstanding = cnt_q;
  assign err         = err_q;

endmodule
